// File: rtl/ascon_perm_seq_pkg.sv
// ascon_perm_pkg: shared constants, FSM encoding and lane helpers for the masked Ascon permutation
package ascon_perm_pkg;
   localparam int MAX_ROUNDS = 12;
   localparam int RAND_W = 320;
   localparam int ROUND_PIPE_LAT = 2;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} seq_state_t;
   localparam logic [7:0] RC [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                      8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
   function automatic logic [63:0] lane(input logic [319:0] s, input int i);
      return s[64*i +: 64];
   endfunction
   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction
   function automatic logic [63:0] lin(input logic [63:0] x, input int i);
      return i == 0 ? x ^ ror(x, 19) ^ ror(x, 28) :
             i == 1 ? x ^ ror(x, 61) ^ ror(x, 39) :
             i == 2 ? x ^ ror(x, 1) ^ ror(x, 6) :
             i == 3 ? x ^ ror(x, 10) ^ ror(x, 17) :
                      x ^ ror(x, 7) ^ ror(x, 41);
   endfunction
endpackage

// File: rtl/ascon_perm_seq_if.sv
// ascon_perm_seq_if: controller-side bundle of the masked permutation sequencer
interface ascon_perm_seq_if;
   import ascon_perm_pkg::*;
   logic start_i;
   logic [3:0] rounds_i;
   logic [319:0] state_a_i, state_b_i;
   logic [RAND_W-1:0] rand_i;
   logic rand_valid_i, rand_ready_o, busy_o, done_o;
   logic [319:0] state_a_o, state_b_o;
   modport master(output start_i, rounds_i, state_a_i, state_b_i, rand_i, rand_valid_i,
                  input rand_ready_o, busy_o, done_o, state_a_o, state_b_o);
   modport slave(input start_i, rounds_i, state_a_i, state_b_i, rand_i, rand_valid_i,
                 output rand_ready_o, busy_o, done_o, state_a_o, state_b_o);
endinterface

// File: rtl/ascon_perm_seq_round.sv
// ascon_round: 2-share DOM-masked Ascon round, cross terms registered in stage 1, result in stage 2
module ascon_round
   import ascon_perm_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [319:0] a,
   input  logic [319:0] b,
   input  logic [320:0] rnd,
   output logic [319:0] out_a,
   output logic [319:0] out_b
);
   logic [63:0] ya [5], yb [5], ca_d [5], cb_d [5], ca [5], cb [5], sa [5], sb [5];
   logic [319:0] da, db;
   always_comb begin
      da = '0;
      db = '0;
      for (int i = 0; i < 5; i++) begin
         ya[i] = lane(a, i);
         yb[i] = lane(b, i);
      end
      ya[2][7:0] = ya[2][7:0] ^ 8'h4b;
      ya[0] = ya[0] ^ ya[4];
      ya[4] = ya[4] ^ ya[3];
      ya[2] = ya[2] ^ ya[1];
      yb[0] = yb[0] ^ yb[4];
      yb[4] = yb[4] ^ yb[3];
      yb[2] = yb[2] ^ yb[1];
      // NOT of the first AND operand lives on share A only
      for (int i = 0; i < 5; i++) begin
         ca_d[i] = (~ya[(i+1)%5] & yb[(i+2)%5]) ^ rnd[64*i +: 64];
         cb_d[i] = (yb[(i+1)%5] & ya[(i+2)%5]) ^ rnd[64*i +: 64];
         sa[i] = ya[i] ^ (~ya[(i+1)%5] & ya[(i+2)%5]) ^ ca[i];
         sb[i] = yb[i] ^ (yb[(i+1)%5] & yb[(i+2)%5]) ^ cb[i];
      end
      sa[1] = sa[1] ^ sa[0];
      sa[0] = sa[0] ^ sa[4];
      sa[3] = sa[3] ^ sa[2];
      sa[2] = ~sa[2];
      sb[1] = sb[1] ^ sb[0];
      sb[0] = sb[0] ^ sb[4];
      sb[3] = sb[3] ^ sb[2];
      for (int i = 0; i < 5; i++) begin
         da[64*i +: 64] = lin(sa[i], i);
         db[64*i +: 64] = lin(sb[i], i);
      end
      da[0] = da[0] ^ rnd[320];
      db[0] = db[0] ^ rnd[320];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ca <= '{default: '0};
         cb <= '{default: '0};
         out_a <= '0;
         out_b <= '0;
      end else begin
         ca <= ca_d;
         cb <= cb_d;
         out_a <= da;
         out_b <= db;
      end
   end
endmodule

// File: rtl/ascon_perm_seq.sv
// ascon_perm_seq: drives the masked Ascon round for 1..12 rounds with fresh randomness per round
module ascon_perm_seq
   import ascon_perm_pkg::*;
(
   input logic clk_i,
   input logic rst_i,
   ascon_perm_seq_if.slave bus
);
   seq_state_t st, nst;
   logic [3:0] r_idx, n;
   logic [7:0] rc;
   logic [319:0] sa, sb, sa_d, sb_d, ra, rb, ina;
   assign n = bus.rounds_i > 4'(MAX_ROUNDS) ? 4'(MAX_ROUNDS) : bus.rounds_i;
   assign rc = r_idx < 4'(MAX_ROUNDS) ? RC[r_idx] : 8'h00;
   // the round already folds in 8'h4b, so pre-cancel it to land on RC[r_idx]
   assign ina = sa ^ {184'b0, rc ^ 8'h4b, 128'b0};
   assign bus.rand_ready_o = st == ISSUE;
   assign bus.busy_o = st != IDLE;
   assign bus.done_o = st == DONE;
   ascon_round u_round (
      .clk(clk_i),
      .rst(!rst_i),
      .a(ina),
      .b(sb),
      .rnd({1'b0, bus.rand_i}),
      .out_a(ra),
      .out_b(rb)
   );
   always_comb begin
      nst = st;
      sa_d = sa;
      sb_d = sb;
      case (st)
         IDLE: if (bus.start_i) begin
            nst = n == 4'd0 ? DONE : ISSUE;
            sa_d = bus.state_a_i;
            sb_d = bus.state_b_i;
         end
         ISSUE: nst = bus.rand_valid_i ? WAIT : ISSUE;
         WAIT: nst = CAPTURE;
         CAPTURE: begin
            nst = r_idx == 4'(MAX_ROUNDS - 1) ? DONE : ISSUE;
            sa_d = ra;
            sb_d = rb;
         end
         default: nst = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         st <= IDLE;
         r_idx <= '0;
         sa <= '0;
         sb <= '0;
         bus.state_a_o <= '0;
         bus.state_b_o <= '0;
      end else begin
         st <= nst;
         sa <= sa_d;
         sb <= sb_d;
         r_idx <= st == IDLE && bus.start_i ? 4'(MAX_ROUNDS) - n : st == CAPTURE ? r_idx + 4'd1 : r_idx;
         if (nst == DONE) begin
            bus.state_a_o <= sa_d;
            bus.state_b_o <= sb_d;
         end
      end
   end
endmodule

// File: tb/tb_ascon_perm_seq.sv
// tb_ascon_perm_seq: randomized checks of the masked sequencer against a plain Ascon permutation model
module tb_ascon_perm_seq;
   logic clk = 0, rst = 0;
   int checks = 0, errors = 0;
   ascon_perm_seq_if bus();
   ascon_perm_seq dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] rot(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction
   function automatic logic [319:0] perm(input logic [319:0] s, input int n);
      logic [63:0] x [5], t [5];
      logic [319:0] r;
      for (int i = 0; i < 5; i++) x[i] = s[64*i +: 64];
      for (int k = 12 - n; k < 12; k++) begin
         x[2] = x[2] ^ 64'((15 - k) * 16 + k);
         x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
         for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i+1)%5];
         for (int i = 0; i < 5; i++) x[i] ^= t[(i+1)%5];
         x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
         x[0] ^= rot(x[0], 19) ^ rot(x[0], 28);
         x[1] ^= rot(x[1], 61) ^ rot(x[1], 39);
         x[2] ^= rot(x[2], 1) ^ rot(x[2], 6);
         x[3] ^= rot(x[3], 10) ^ rot(x[3], 17);
         x[4] ^= rot(x[4], 7) ^ rot(x[4], 41);
      end
      for (int i = 0; i < 5; i++) r[64*i +: 64] = x[i];
      return r;
   endfunction
   function automatic logic [319:0] rnd320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction
   task automatic run(input logic [319:0] a, input logic [319:0] b, input logic [3:0] r,
                      input int stall_at, input int stall_len, input bit rstall, input bit poke,
                      output int lat, output int stalls, output int readies);
      int hs = 0;
      bit seen = 0;
      stalls = 0; readies = 0; lat = -1;
      @(negedge clk);
      bus.state_a_i = a; bus.state_b_i = b; bus.rounds_i = r; bus.start_i = 1;
      for (int k = 1; k <= 400 && !seen; k++) begin
         @(negedge clk);
         bus.start_i = poke && k == 5;
         bus.state_a_i = rnd320(); bus.state_b_i = rnd320(); bus.rounds_i = 4'($urandom);
         if (k == 1 && r != 0) check("busy_run", 320'(bus.busy_o), 320'(1));
         if (bus.rand_ready_o) begin
            readies++;
            if ((hs == stall_at && stalls < stall_len) || (rstall && $urandom_range(0, 3) == 0)) begin
               bus.rand_valid_i = 0;
               stalls++;
            end else begin
               bus.rand_valid_i = 1;
               hs++;
            end
         end else bus.rand_valid_i = 1'($urandom);
         bus.rand_i = rnd320();
         if (bus.done_o) begin
            seen = 1;
            lat = k;
            bus.start_i = poke;
         end
      end
      if (!seen) check("timeout", 320'(0), 320'(1));
      @(negedge clk);
      bus.start_i = 0;
   endtask
   initial begin
      int lat, st, rd, dones;
      logic [319:0] a, b, x, m, oa, ob;
      bus.start_i = 0; bus.rounds_i = 0; bus.state_a_i = 0; bus.state_b_i = 0;
      bus.rand_i = 0; bus.rand_valid_i = 0;
      repeat (3) @(negedge clk);
      check("rst_done", 320'(bus.done_o), 320'(0));
      check("rst_busy", 320'(bus.busy_o), 320'(0));
      check("rst_ready", 320'(bus.rand_ready_o), 320'(0));
      check("rst_out_a", bus.state_a_o, 320'(0));
      check("rst_out_b", bus.state_b_o, 320'(0));
      rst = 1;
      a = {256'h0, 64'h80400c0600000000};
      run(a, 320'(0), 4'd12, -1, 0, 0, 0, lat, st, rd);
      check("p12_lat", 320'(lat), 320'(37));
      check("p12", bus.state_a_o ^ bus.state_b_o, perm(a, 12));
      check("idle_busy", 320'(bus.busy_o), 320'(0));
      for (int t = 0; t < 50; t++) begin
         x = rnd320(); m = rnd320();
         run(x ^ m, m, 4'd12, -1, 0, 1, 0, lat, st, rd);
         check("mask_lat", 320'(lat), 320'(37 + st));
         check("mask", bus.state_a_o ^ bus.state_b_o, perm(x, 12));
      end
      x = rnd320(); m = rnd320();
      run(x ^ m, m, 4'd6, -1, 0, 0, 0, lat, st, rd);
      check("p6_lat", 320'(lat), 320'(19));
      check("p6", bus.state_a_o ^ bus.state_b_o, perm(x, 6));
      a = rnd320(); b = rnd320();
      run(a, b, 4'd0, -1, 0, 0, 0, lat, st, rd);
      check("p0_lat", 320'(lat), 320'(1));
      check("p0_a", bus.state_a_o, a);
      check("p0_b", bus.state_b_o, b);
      x = rnd320(); m = rnd320();
      run(x ^ m, m, 4'd15, -1, 0, 0, 0, lat, st, rd);
      check("p15_lat", 320'(lat), 320'(37));
      check("p15", bus.state_a_o ^ bus.state_b_o, perm(x, 12));
      run(x ^ m, m, 4'd12, 2, 5, 0, 0, lat, st, rd);
      check("stall_lat", 320'(lat), 320'(42));
      check("stall_ready", 320'(rd), 320'(17));
      check("stall", bus.state_a_o ^ bus.state_b_o, perm(x, 12));
      @(negedge clk);
      bus.state_a_i = x ^ m; bus.state_b_i = m; bus.rounds_i = 4'd12; bus.start_i = 1; bus.rand_valid_i = 1;
      repeat (10) begin
         @(negedge clk);
         bus.start_i = 0;
         bus.rand_i = rnd320();
      end
      rst = 0;
      @(negedge clk);
      check("abort_done", 320'(bus.done_o), 320'(0));
      check("abort_busy", 320'(bus.busy_o), 320'(0));
      check("abort_ready", 320'(bus.rand_ready_o), 320'(0));
      check("abort_out_a", bus.state_a_o, 320'(0));
      check("abort_out_b", bus.state_b_o, 320'(0));
      repeat (2) begin
         @(negedge clk);
         check("abort_nodone", 320'(bus.done_o), 320'(0));
      end
      rst = 1;
      x = rnd320(); m = rnd320();
      run(x ^ m, m, 4'd12, -1, 0, 1, 0, lat, st, rd);
      check("fresh_lat", 320'(lat), 320'(37 + st));
      check("fresh", bus.state_a_o ^ bus.state_b_o, perm(x, 12));
      x = rnd320(); m = rnd320();
      run(x ^ m, m, 4'd12, -1, 0, 0, 1, lat, st, rd);
      check("poke_lat", 320'(lat), 320'(37));
      oa = bus.state_a_o; ob = bus.state_b_o;
      check("poke", oa ^ ob, perm(x, 12));
      dones = 0;
      repeat (45) begin
         @(negedge clk);
         bus.rand_valid_i = 1;
         bus.rand_i = rnd320();
         if (bus.done_o) dones++;
      end
      check("poke_extra_done", 320'(dones), 320'(0));
      check("hold_a", bus.state_a_o, oa);
      check("hold_b", bus.state_b_o, ob);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
